// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   state_t   - arbiter FSM states (IDLE, ISSUE, WAIT, ACK)
//   owner_t   - which port owns the memory (OWN_INSTR, OWN_DATA)
//   LAT_CNT_W - width of the read-latency counter (covers MEM_LATENCY 1..15)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_arb2_grant.sv
// arb2_grant: two-way grant decision between the instruction and data ports.
// Optional feature macro: MEM_ARB_RR_EN
//   defined   -> round-robin: on a tie the port not granted last wins
//   undefined -> fixed priority: on a tie the data port always wins
// A lone request wins immediately in either mode.
// Ports:
//   clk, rstz  - clock, synchronous active-low reset
//   instr_req  - instruction port request
//   data_req   - data port request
//   take       - the arbiter accepts the current grant this cycle
//   grant      - combinational winner (meaningful only when a req is high)
module arb2_grant
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rstz,
    input  logic   instr_req,
    input  logic   data_req,
    input  logic   take,
    output owner_t grant
);

    // Last owner; resets to data so the first tie under round-robin goes to instr.
    owner_t last_owner;

    always_ff @(posedge clk) begin
        if (!rstz) begin
            last_owner <= OWN_DATA;
        end else if (take) begin
            last_owner <= grant;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant = OWN_INSTR;
        if (instr_req && data_req) begin
            grant = (last_owner == OWN_DATA) ? OWN_INSTR : OWN_DATA;
        end else if (data_req) begin
            grant = OWN_DATA;
        end
    end
`else
    // Pointer is kept for a uniform reset state but does not steer fixed priority.
    logic last_owner_unused;
    assign last_owner_unused = (last_owner == OWN_DATA);

    always_comb begin
        grant = OWN_INSTR;
        if (data_req || !instr_req) begin
            grant = OWN_DATA;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a read-only instruction
// port and a read/write data port.
// Optional feature macro: MEM_ARB_RR_EN (round-robin ties; default fixed data priority).
// Handshake: a requester raises req with stable fields and holds them until its
// ack; ack is a single-cycle pulse carrying the read data on that port's output.
// Ports:
//   clk, rstz                                   - clock, synchronous active-low reset
//   instr_addr/instr_req -> instr_data/instr_ack - instruction read port
//   data_addr/data_wr_data/data_mask/data_wr_en/data_req
//                        -> data_rd_data/data_ack - data port
//   mem_addr/mem_wr_data/mem_mask/mem_wr_en/mem_en, mem_rd_data - memory side
//   busy        - FSM not in IDLE
//   grant_data  - current/last owner is the data port
//   dbg_state   - FSM state for observation
// Parameter MEM_LATENCY (1..15): cycles from mem_en to valid mem_rd_data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1
)
(
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_ack,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic [31:0] data_rd_data,
    output logic        data_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_mask,
    output logic        mem_wr_en,
    output logic        mem_en,
    input  logic [31:0] mem_rd_data,
    output logic        busy,
    output logic        grant_data,
    output state_t      dbg_state
);

    localparam logic [LAT_CNT_W-1:0] WAIT_LOAD = LAT_CNT_W'(MEM_LATENCY - 1);

    state_t                 state;
    logic [LAT_CNT_W-1:0]   lat_cnt;
    owner_t                 grant;
    logic                   take;

    assign take      = (state == IDLE) && (instr_req || data_req);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    arb2_grant u_grant (
        .clk       (clk),
        .rstz      (rstz),
        .instr_req (instr_req),
        .data_req  (data_req),
        .take      (take),
        .grant     (grant)
    );

    // mem_addr/mem_wr_data/mem_mask double as the latched request fields; they
    // only change when a new request is accepted in IDLE. mem_wr_en is nonzero
    // only during ISSUE, so in ISSUE it also tells write from read.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            grant_data   <= 1'b0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
            mem_mask     <= '0;
            mem_wr_en    <= 1'b0;
            mem_en       <= 1'b0;
            instr_ack    <= 1'b0;
            data_ack     <= 1'b0;
            instr_data   <= '0;
            data_rd_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state  <= ISSUE;
                        mem_en <= 1'b1;
                        if (grant == OWN_DATA) begin
                            grant_data  <= 1'b1;
                            mem_addr    <= data_addr;
                            mem_wr_data <= data_wr_data;
                            mem_mask    <= data_mask;
                            mem_wr_en   <= data_wr_en;
                        end else begin
                            grant_data  <= 1'b0;
                            mem_addr    <= instr_addr;
                            mem_wr_data <= '0;
                            mem_mask    <= 4'hF;
                            mem_wr_en   <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_wr_en <= 1'b0;
                    if (mem_wr_en) begin
                        // Only the data port can write; its read data is left untouched.
                        state    <= ACK;
                        data_ack <= 1'b1;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= ACK;
                        if (grant_data) begin
                            data_rd_data <= mem_rd_data;
                            data_ack     <= 1'b1;
                        end else begin
                            instr_data <= mem_rd_data;
                            instr_ack  <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ACK: begin
                    instr_ack <= 1'b0;
                    data_ack  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (MEM_LATENCY = 3).
// Drivers issue requests and push expected responses into per-port queues; a
// negedge monitor pops and compares on every ack and checks grant choice,
// memory-side fields and ack latency. A behavioural memory returns read data
// exactly MEM_LATENCY cycles after mem_en and random noise otherwise.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic [31:0] instr_addr = '0;
    logic        instr_req = 1'b0;
    logic [31:0] instr_data;
    logic        instr_ack;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wr_data = '0;
    logic [3:0]  data_mask = '0;
    logic        data_wr_en = 1'b0;
    logic        data_req = 1'b0;
    logic [31:0] data_rd_data;
    logic        data_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_mask;
    logic        mem_wr_en;
    logic        mem_en;
    logic [31:0] mem_rd_data = '0;
    logic        busy;
    logic        grant_data;
    state_t      dbg_state;

    mem_arbiter #(.MEM_LATENCY(LAT)) dut (
        .clk          (clk),
        .rstz         (rstz),
        .instr_addr   (instr_addr),
        .instr_req    (instr_req),
        .instr_data   (instr_data),
        .instr_ack    (instr_ack),
        .data_addr    (data_addr),
        .data_wr_data (data_wr_data),
        .data_mask    (data_mask),
        .data_wr_en   (data_wr_en),
        .data_req     (data_req),
        .data_rd_data (data_rd_data),
        .data_ack     (data_ack),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_mask     (mem_mask),
        .mem_wr_en    (mem_wr_en),
        .mem_en       (mem_en),
        .mem_rd_data  (mem_rd_data),
        .busy         (busy),
        .grant_data   (grant_data),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory contents ----------------
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Behavioural memory seen by the DUT.
    logic [31:0] mem_store [logic [31:0]];
    int          rd_due = -1;
    logic [31:0] rd_val = '0;

    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : init_word(a);
    endfunction

    always @(negedge clk) begin
        if (mem_en && !mem_wr_en) begin
            rd_due = cyc + LAT;
            rd_val = mem_peek(mem_addr);
        end
        if (mem_en && mem_wr_en) mem_store[mem_addr] = merge(mem_peek(mem_addr), mem_wr_data, mem_mask);
        mem_rd_data = (cyc == rd_due) ? rd_val : $urandom();
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_rd_model = '0;
    logic [31:0] instr_exp_q[$];
    logic [31:0] data_exp_q[$];
    logic        model_last = 1'b1;   // 1 = data owned last

    function automatic logic [31:0] ref_peek(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic model_grant(input logic ri, input logic rd, input logic last);
`ifdef MEM_ARB_RR_EN
        if (ri && rd) return !last;
`else
        if (ri && rd) return 1'b1;
`endif
        return rd;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic pi_q = 1'b0, pd_q = 1'b0;
    always @(posedge clk) begin
        pi_q <= instr_req;
        pd_q <= data_req;
    end

    bit   busy_log [int];
    logic ack_log[$];
    int   last_issue_cyc = -100;
    logic issue_wr = 1'b0;
    logic in_flight = 1'b0;
    logic mem_en_prev = 1'b0;

    always @(negedge clk) begin
        logic g;
        busy_log[cyc] = busy;
        if (!rstz) begin
            model_last    = 1'b1;
            in_flight     = 1'b0;
            mem_en_prev   = 1'b0;
            last_rd_model = '0;
        end else begin
            if (mem_en) begin
                chk("mem_en_single", {31'd0, mem_en_prev}, 32'd0);
                g = model_grant(pi_q, pd_q, model_last);
                chk("grant_owner", {31'd0, grant_data}, {31'd0, g});
                model_last = g;
                if (g) begin
                    chk("d_mem_addr", mem_addr, data_addr);
                    chk("d_mem_mask", {28'd0, mem_mask}, {28'd0, data_mask});
                    chk("d_mem_wr_en", {31'd0, mem_wr_en}, {31'd0, data_wr_en});
                    if (data_wr_en) chk("d_mem_wr_data", mem_wr_data, data_wr_data);
                end else begin
                    chk("i_mem_addr", mem_addr, instr_addr);
                    chk("i_mem_mask", {28'd0, mem_mask}, 32'hF);
                    chk("i_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
                end
                last_issue_cyc = cyc;
                issue_wr       = mem_wr_en;
                in_flight      = 1'b1;
            end else if (mem_wr_en) begin
                chk("wr_en_outside_issue", {31'd0, mem_wr_en}, 32'd0);
            end
            mem_en_prev = mem_en;

            if (instr_ack && data_ack) chk("single_ack", 32'd2, 32'd1);
            if (instr_ack || data_ack) begin
                chk("ack_in_flight", {31'd0, in_flight}, 32'd1);
                chk("ack_latency", 32'(cyc - last_issue_cyc), issue_wr ? 32'd1 : 32'(1 + LAT));
                in_flight = 1'b0;
            end
            if (instr_ack) begin
                ack_log.push_back(1'b0);
                if (instr_exp_q.size() == 0) chk("instr_unexpected_ack", 32'd1, 32'd0);
                else chk("instr_data", instr_data, instr_exp_q.pop_front());
            end
            if (data_ack) begin
                ack_log.push_back(1'b1);
                if (data_exp_q.size() == 0) chk("data_unexpected_ack", 32'd1, 32'd0);
                else chk("data_rd_data", data_rd_data, data_exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic wait_ack(input logic is_data, input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (is_data ? data_ack : instr_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) chk(name, 32'd0, 32'd1);
    endtask

    task automatic instr_txn(input logic [31:0] a);
        instr_req  = 1'b1;
        instr_addr = a;
        instr_exp_q.push_back(init_word(a));
        wait_ack(1'b0, "instr_ack_timeout");
    endtask

    task automatic data_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m);
        data_req     = 1'b1;
        data_wr_en   = wr;
        data_addr    = a;
        data_wr_data = d;
        data_mask    = m;
        if (wr) begin
            ref_mem[a] = merge(ref_peek(a), d, m);
            data_exp_q.push_back(last_rd_model);
        end else begin
            last_rd_model = ref_peek(a);
            data_exp_q.push_back(last_rd_model);
        end
        wait_ack(1'b1, "data_ack_timeout");
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int   c0;
        int   n_ack;
        logic first;
        logic exp_order[$];

        // Reset state
        rstz = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_instr_ack", {31'd0, instr_ack}, 32'd0);
        chk("rst_data_ack", {31'd0, data_ack}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant_data", {31'd0, grant_data}, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_instr_data", instr_data, 32'd0);
        chk("rst_data_rd_data", data_rd_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_mask", {28'd0, mem_mask}, 32'd0);
        rstz = 1'b1;
        @(negedge clk);

        // Instruction read from 0x10 -> 0xDEADBEEF
        c0 = cyc;
        instr_txn(32'h10);
        instr_req = 1'b0;
        chk("instr_issue_cycle", 32'(last_issue_cyc - c0), 32'd1);
        chk("instr_ack_cycle", 32'(cyc - c0), 32'(2 + LAT));
        @(negedge clk);

        // Data write 0x20 / 0x12345678 / mask 0011
        c0 = cyc;
        data_txn(1'b1, 32'h20, 32'h12345678, 4'b0011);
        data_req = 1'b0;
        chk("write_issue_cycle", 32'(last_issue_cyc - c0), 32'd1);
        chk("write_ack_cycle", 32'(cyc - c0), 32'd2);
        @(negedge clk);

        // Data read back with latency and busy window
        c0 = cyc;
        data_txn(1'b0, 32'h20, 32'h0, 4'h0);
        data_req = 1'b0;
        chk("read_ack_cycle", 32'(cyc - c0), 32'(2 + LAT));
        @(negedge clk);
        chk("busy_before", {31'd0, busy_log[c0]}, 32'd0);
        for (int k = 1; k <= 2 + LAT; k++) chk("busy_window", {31'd0, busy_log[c0 + k]}, 32'd1);
        chk("busy_after", {31'd0, busy_log[c0 + 3 + LAT]}, 32'd0);

        // Both requests held continuously for four grants
        ack_log.delete();
        exp_order.delete();
        first = model_last;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_order.push_back(!first ^ k[0]);
`else
            exp_order.push_back(1'b1);
`endif
        end
        foreach (exp_order[k]) begin
            if (exp_order[k]) data_exp_q.push_back(ref_peek(32'h24));
            else instr_exp_q.push_back(init_word(32'h44));
        end
        last_rd_model = ref_peek(32'h24);
        instr_addr = 32'h44; instr_req = 1'b1;
        data_addr = 32'h24; data_wr_en = 1'b0; data_mask = 4'hF; data_req = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 200 && n_ack < 4; i++) begin
            @(negedge clk);
            if (instr_ack || data_ack) n_ack++;
        end
        instr_req = 1'b0;
        data_req  = 1'b0;
        chk("arb_ack_count", 32'(n_ack), 32'd4);
        @(negedge clk);
        chk("arb_log_size", 32'(ack_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < ack_log.size(); k++)
            chk("arb_order", {31'd0, ack_log[k]}, {31'd0, exp_order[k]});

        // Reset during WAIT aborts the read
        @(negedge clk);
        data_addr = 32'h28; data_wr_en = 1'b0; data_req = 1'b1;
        for (int i = 0; i < 20 && !mem_en; i++) @(negedge clk);
        chk("abort_issue_seen", {31'd0, mem_en}, 32'd1);
        @(negedge clk);
        rstz = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        chk("abort_no_iack", {31'd0, instr_ack}, 32'd0);
        chk("abort_no_dack", {31'd0, data_ack}, 32'd0);
        chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_state", 32'(dbg_state), 32'(IDLE));
        chk("abort_rd_cleared", data_rd_data, 32'd0);
        @(negedge clk);
        rstz = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        data_txn(1'b0, 32'h20, 32'h0, 4'h0);
        data_req = 1'b0;
        @(negedge clk);

        // Randomized concurrent traffic
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int gap;
                    instr_txn(32'h1000_0000 + (32'($urandom_range(0, 255)) << 2));
                    gap = $urandom_range(0, 3);
                    if (gap != 0) begin
                        instr_req = 1'b0;
                        repeat (gap) @(negedge clk);
                    end
                end
                instr_req = 1'b0;
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    int gap;
                    data_txn(1'($urandom_range(0, 1)), 32'h2000_0000 + (32'($urandom_range(0, 7)) << 2),
                             $urandom(), 4'($urandom_range(0, 15)));
                    gap = $urandom_range(0, 3);
                    if (gap != 0) begin
                        data_req = 1'b0;
                        repeat (gap) @(negedge clk);
                    end
                end
                data_req = 1'b0;
            end
        join

        repeat (LAT + 4) @(negedge clk);
        chk("instr_q_drained", 32'(instr_exp_q.size()), 32'd0);
        chk("data_q_drained", 32'(data_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
